dmem_lsu: RTL and testbench

- Load/store initiator that drives the four byte-lane data BRAM banks on behalf of the core's MEM stage.
- Lane i holds byte i of each 32-bit word.
- Accepts one word-level RV32 load/store request at a time and issues per-lane addresses and enables.
- Misaligned accesses that cross a word boundary complete in a single bank access.
- For loads, it rotates, sign/zero-extends and returns the data. For every request it returns a response, either data, store ack or error.

---
 rtl/dmem_lsu_pkg.sv | 26 ++
 rtl/dmem_load_align.sv | 33 +++
 rtl/dmem_lsu.sv | 129 ++++++++++++
 tb/tb_dmem_lsu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the byte-lane data memory load/store unit.
// RV32 funct3 size codes, FSM encoding and lane-address width helper.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RSP_LD = 2'd1,
    ST_RSP_ST = 2'd2,
    ST_RSP_ER = 2'd3
  } state_e;

  // Each bank holds one byte per word, so it is addressed by the word index.
  function automatic int lane_aw(input int addr_width);
    return addr_width - 2;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Rotates the four bank bytes so access byte 0 lands in bits 7:0, then extends.
// Purely combinational; no state, no handshake.
module dmem_load_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [4:0]  sh_r;
  logic [5:0]  sh_l;
  logic [31:0] rot;

  assign sh_r = {off, 3'b000};
  assign sh_l = 6'd32 - {1'b0, sh_r};
  // A left shift by 32 yields zero, so off=0 degenerates to a plain copy.
  assign rot  = (raw >> sh_r) | (raw << sh_l);

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{24{rot[7]}}, rot[7:0]};
      F3_LH:   result = {{16{rot[15]}}, rot[15:0]};
      F3_LW:   result = rot;
      F3_LBU:  result = {24'd0, rot[7:0]};
      F3_LHU:  result = {16'd0, rot[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for four byte-lane BRAM banks; one request in flight.
// Response one cycle after accept; a held response blocks new requests unless consumed.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic                        REQ_WE,
  input  logic [2:0]                  REQ_FUNCT3,
  input  logic [ADDR_WIDTH-1:0]       REQ_ADDR,
  input  logic [31:0]                 REQ_WDATA,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [31:0]                 RSP_RDATA,
  output logic                        RSP_ERR,
  output logic [4*(ADDR_WIDTH-2)-1:0] BANK_WADDR,
  output logic [4*(ADDR_WIDTH-2)-1:0] BANK_RADDR,
  output logic [3:0]                  BANK_WE,
  output logic [3:0]                  BANK_RE,
  output logic [31:0]                 BANK_DIN,
  input  logic [31:0]                 BANK_DOUT
);

  localparam int LAW = lane_aw(ADDR_WIDTH);
  localparam logic [LAW-1:0] LAST_W = '1;

  state_e         state_q, state_d;
  logic [1:0]     off_q;
  logic [2:0]     f3_q;
  logic [LAW-1:0] w, w_nx;
  logic [1:0]     off;
  logic [2:0]     size;
  logic           legal, err, accept, consume;
  logic [31:0]    ld_data;

  assign w    = REQ_ADDR[ADDR_WIDTH-1:2];
  assign off  = REQ_ADDR[1:0];
  assign w_nx = w + LAW'(1);

  always_comb begin
    size = 3'd0;
    case (REQ_FUNCT3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      2'b10:   size = 3'd4;
      default: size = 3'd0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    if (REQ_WE)
      legal = (REQ_FUNCT3 == F3_SB) || (REQ_FUNCT3 == F3_SH) || (REQ_FUNCT3 == F3_SW);
    else
      legal = (REQ_FUNCT3 == F3_LB) || (REQ_FUNCT3 == F3_LH) || (REQ_FUNCT3 == F3_LW) ||
              (REQ_FUNCT3 == F3_LBU) || (REQ_FUNCT3 == F3_LHU);
  end

  // The last word has no successor: a crossing access there is rejected, not wrapped.
  assign err = !legal || ((w == LAST_W) && (({1'b0, off} + size) > 3'd4));

  assign RSP_VALID = (state_q != ST_IDLE);
  assign consume   = RSP_VALID && RSP_READY;
  // Gating with RST_N keeps enables dead on an edge that coincides with reset.
  assign REQ_READY = RST_N && ((state_q == ST_IDLE) || consume);
  assign accept    = REQ_VALID && REQ_READY;

  always_comb begin
    logic [1:0] k;
    logic       used;
    BANK_WADDR = '0;
    BANK_RADDR = '0;
    BANK_WE    = '0;
    BANK_RE    = '0;
    BANK_DIN   = '0;
    k          = '0;
    used       = 1'b0;
    for (int l = 0; l < 4; l++) begin
      k    = 2'(l) - off;
      used = ({1'b0, k} < size);
      // Lanes below the offset hold the bytes that spilled into the next word.
      BANK_RADDR[l*LAW +: LAW] = (used && (2'(l) < off)) ? w_nx : w;
      BANK_WADDR[l*LAW +: LAW] = (used && (2'(l) < off)) ? w_nx : w;
      BANK_DIN[l*8 +: 8]       = used ? REQ_WDATA[{k, 3'b000} +: 8] : 8'd0;
      BANK_WE[l]               = accept && !err && REQ_WE && used;
      BANK_RE[l]               = accept && !err && !REQ_WE && used;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (err)         state_d = ST_RSP_ER;
      else if (REQ_WE) state_d = ST_RSP_ST;
      else             state_d = ST_RSP_LD;
    end else if (consume) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      if (accept && !err && !REQ_WE) begin
        off_q <= off;
        f3_q  <= REQ_FUNCT3;
      end
    end
  end

  dmem_load_align u_align (
    .raw    (BANK_DOUT),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ld_data)
  );

  assign RSP_RDATA = (state_q == ST_RSP_LD) ? ld_data : 32'd0;
  assign RSP_ERR   = (state_q == ST_RSP_ER);

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural four-bank byte memory.
module tb_dmem_lsu;

  localparam int AW  = 8;
  localparam int LAW = 6;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            REQ_VALID = 1'b0;
  logic            REQ_READY;
  logic            REQ_WE = 1'b0;
  logic [2:0]      REQ_FUNCT3 = 3'd0;
  logic [AW-1:0]   REQ_ADDR = '0;
  logic [31:0]     REQ_WDATA = '0;
  logic            RSP_VALID;
  logic            RSP_READY = 1'b0;
  logic [31:0]     RSP_RDATA;
  logic            RSP_ERR;
  logic [4*LAW-1:0] BANK_WADDR, BANK_RADDR;
  logic [3:0]      BANK_WE, BANK_RE;
  logic [31:0]     BANK_DIN;
  logic [31:0]     BANK_DOUT = '0;

  int errors = 0;
  int checks = 0;

  dmem_lsu #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .BANK_WADDR(BANK_WADDR), .BANK_RADDR(BANK_RADDR), .BANK_WE(BANK_WE), .BANK_RE(BANK_RE),
    .BANK_DIN(BANK_DIN), .BANK_DOUT(BANK_DOUT)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [4][64];

  always @(posedge CLK) begin
    for (int l = 0; l < 4; l++) begin
      if (BANK_WE[l]) mem[l][BANK_WADDR[l*LAW +: LAW]] <= BANK_DIN[l*8 +: 8];
      if (BANK_RE[l]) BANK_DOUT[l*8 +: 8] <= mem[l][BANK_RADDR[l*LAW +: LAW]];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  re_e;
    logic [3:0]  we_e;
    logic        chk_addr;
    logic [23:0] addr_e;
    logic [31:0] din_e;
    logic [31:0] rdata_e;
    logic        err_e;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [7:0] a,
                              input logic [31:0] wd, input logic [3:0] re, input logic [3:0] wee,
                              input logic ca, input logic [23:0] ae, input logic [31:0] de,
                              input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.re_e = re; v.we_e = wee;
    v.chk_addr = ca; v.addr_e = ae; v.din_e = de; v.rdata_e = rd; v.err_e = er;
    return v;
  endfunction

  function automatic logic [23:0] a4(input logic [5:0] l3, input logic [5:0] l2,
                                     input logic [5:0] l1, input logic [5:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [31:0] mask;
    v = vt[i];
    mask = '0;
    for (int l = 0; l < 4; l++) mask[l*8 +: 8] = {8{v.we_e[l]}};
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = v.we; REQ_FUNCT3 = v.f3; REQ_ADDR = v.addr;
    REQ_WDATA = v.wdata; RSP_READY = 1'b1;
    #1;
    chk($sformatf("v%0d req_ready", i), 32'(REQ_READY), 32'd1);
    chk($sformatf("v%0d bank_re", i), 32'(BANK_RE), 32'(v.re_e));
    chk($sformatf("v%0d bank_we", i), 32'(BANK_WE), 32'(v.we_e));
    if (v.chk_addr) begin
      chk($sformatf("v%0d raddr", i), 32'(BANK_RADDR), 32'(v.addr_e));
      chk($sformatf("v%0d waddr", i), 32'(BANK_WADDR), 32'(v.addr_e));
    end
    chk($sformatf("v%0d din", i), BANK_DIN & mask, v.din_e);
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    chk($sformatf("v%0d rsp_valid", i), 32'(RSP_VALID), 32'd1);
    chk($sformatf("v%0d rdata", i), RSP_RDATA, v.rdata_e);
    chk($sformatf("v%0d err", i), 32'(RSP_ERR), 32'(v.err_e));
  endtask

  initial begin
    vt[0]  = mk(1, 3'b010, 8'h14, 32'h8899AABB, 4'b0000, 4'b1111, 1, a4(5,5,5,5), 32'h8899AABB, 32'h0, 0);
    vt[1]  = mk(1, 3'b010, 8'h18, 32'h11223344, 4'b0000, 4'b1111, 1, a4(6,6,6,6), 32'h11223344, 32'h0, 0);
    vt[2]  = mk(1, 3'b010, 8'hFC, 32'hCAFEF00D, 4'b0000, 4'b1111, 1, a4(63,63,63,63), 32'hCAFEF00D, 32'h0, 0);
    vt[3]  = mk(0, 3'b010, 8'h14, 32'h0, 4'b1111, 4'b0000, 1, a4(5,5,5,5), 32'h0, 32'h8899AABB, 0);
    vt[4]  = mk(0, 3'b000, 8'h17, 32'h0, 4'b1000, 4'b0000, 1, a4(5,5,5,5), 32'h0, 32'hFFFFFF88, 0);
    vt[5]  = mk(0, 3'b100, 8'h17, 32'h0, 4'b1000, 4'b0000, 1, a4(5,5,5,5), 32'h0, 32'h00000088, 0);
    vt[6]  = mk(0, 3'b101, 8'h17, 32'h0, 4'b1001, 4'b0000, 1, a4(5,5,5,6), 32'h0, 32'h00004488, 0);
    vt[7]  = mk(0, 3'b001, 8'h17, 32'h0, 4'b1001, 4'b0000, 1, a4(5,5,5,6), 32'h0, 32'h00004488, 0);
    vt[8]  = mk(1, 3'b001, 8'h17, 32'h1234BEEF, 4'b0000, 4'b1001, 1, a4(5,5,5,6), 32'hEF0000BE, 32'h0, 0);
    vt[9]  = mk(0, 3'b010, 8'h18, 32'h0, 4'b1111, 4'b0000, 1, a4(6,6,6,6), 32'h0, 32'h112233BE, 0);
    vt[10] = mk(0, 3'b010, 8'h14, 32'h0, 4'b1111, 4'b0000, 1, a4(5,5,5,5), 32'h0, 32'hEF99AABB, 0);
    vt[11] = mk(0, 3'b001, 8'h16, 32'h0, 4'b1100, 4'b0000, 1, a4(5,5,5,5), 32'h0, 32'hFFFFEF99, 0);
    vt[12] = mk(1, 3'b000, 8'h15, 32'hFFFFFF5A, 4'b0000, 4'b0010, 1, a4(5,5,5,5), 32'h00005A00, 32'h0, 0);
    vt[13] = mk(0, 3'b010, 8'h14, 32'h0, 4'b1111, 4'b0000, 1, a4(5,5,5,5), 32'h0, 32'hEF995ABB, 0);
    vt[14] = mk(0, 3'b010, 8'hFC, 32'h0, 4'b1111, 4'b0000, 1, a4(63,63,63,63), 32'h0, 32'hCAFEF00D, 0);
    vt[15] = mk(0, 3'b000, 8'hFF, 32'h0, 4'b1000, 4'b0000, 1, a4(63,63,63,63), 32'h0, 32'hFFFFFFCA, 0);
    vt[16] = mk(0, 3'b101, 8'hFF, 32'h0, 4'b0000, 4'b0000, 0, 24'h0, 32'h0, 32'h0, 1);
    vt[17] = mk(0, 3'b010, 8'hFE, 32'h0, 4'b0000, 4'b0000, 0, 24'h0, 32'h0, 32'h0, 1);
    vt[18] = mk(0, 3'b011, 8'h14, 32'h0, 4'b0000, 4'b0000, 0, 24'h0, 32'h0, 32'h0, 1);
    vt[19] = mk(1, 3'b100, 8'h14, 32'h55, 4'b0000, 4'b0000, 0, 24'h0, 32'h0, 32'h0, 1);
    vt[20] = mk(0, 3'b101, 8'h16, 32'h0, 4'b1100, 4'b0000, 1, a4(5,5,5,5), 32'h0, 32'h0000EF99, 0);
    vt[21] = mk(0, 3'b100, 8'h14, 32'h0, 4'b0001, 4'b0000, 1, a4(5,5,5,5), 32'h0, 32'h000000BB, 0);

    // Reset with a store presented: nothing may be accepted or written.
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 8'h14; REQ_WDATA = 32'hDEADDEAD;
    RSP_READY = 1'b1;
    #12;
    chk("rst req_ready", 32'(REQ_READY), 32'd0);
    chk("rst rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst rdata", RSP_RDATA, 32'd0);
    chk("rst err", 32'(RSP_ERR), 32'd0);
    chk("rst bank_we", 32'(BANK_WE), 32'd0);
    chk("rst bank_re", 32'(BANK_RE), 32'd0);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    RST_N = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: response must hold with banks idle, then back-to-back accept.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 8'h14; RSP_READY = 1'b0;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("bp%0d rsp_valid", c), 32'(RSP_VALID), 32'd1);
      chk($sformatf("bp%0d rdata", c), RSP_RDATA, 32'hEF995ABB);
      chk($sformatf("bp%0d req_ready", c), 32'(REQ_READY), 32'd0);
      chk($sformatf("bp%0d bank_re", c), 32'(BANK_RE), 32'd0);
    end
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_ADDR = 8'h18; RSP_READY = 1'b1;
    #1;
    chk("b2b req_ready", 32'(REQ_READY), 32'd1);
    chk("b2b bank_re", 32'(BANK_RE), 32'hF);
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("b2b rsp_valid", 32'(RSP_VALID), 32'd1);
    chk("b2b rdata", RSP_RDATA, 32'h112233BE);

    // Reset while an error response is held.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b011; REQ_ADDR = 8'h14; RSP_READY = 1'b0;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("mid rsp_err", 32'(RSP_ERR), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid rst rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("mid rst rsp_err", 32'(RSP_ERR), 32'd0);
    chk("mid rst req_ready", 32'(REQ_READY), 32'd0);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'b000; REQ_ADDR = 8'h14; REQ_WDATA = 32'h77;
    #1;
    chk("mid rst bank_we", 32'(BANK_WE), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0; RSP_READY = 1'b1; RST_N = 1'b1;
    #1;
    chk("post rst rsp_valid", 32'(RSP_VALID), 32'd0);
    run_vec(13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
